// File: rtl/display_7seg_mux_pkg.sv
// Shared constants and the nibble-to-segment lookup for the multiplexed 7-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package display_7seg_pkg;

    localparam logic [6:0] SEG_ALL_ON = 7'h7F;
    localparam logic [6:0] SEG_OFF    = 7'h00;

    // Index 0 is the rightmost entry; codes 10-15 render as A,b,C,d,E,F.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] seg_v;
        if (!hex_mode && (nibble > 4'd9)) begin
            seg_v = SEG_OFF;
        end else begin
            seg_v = SEG_TABLE[nibble];
        end
        return seg_v;
    endfunction

endpackage

// File: rtl/display_7seg_mux_seg7_decode.sv
// Combinational nibble-to-segment decoder; HEX_MODE=0 blanks codes above 9.
module seg7_decode
    import display_7seg_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the selected nibble
    always_comb begin
        seg = seg7_lookup(nibble, (HEX_MODE != 0));
    end

endmodule

// File: rtl/display_7seg_mux.sv
// Time-multiplexed N-digit 7-segment driver: input latch, refresh prescaler, scan counter,
// lamp test / blanking / leading-zero blanking priority mux and registered outputs.
module display_7seg_mux
    import display_7seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 50000,
    parameter int HEX_MODE       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic                    le,
    input  logic                    lt_n,
    input  logic                    bi_n,
    input  logic                    lzb,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [4*N_DIGITS-1:0] lat_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  tick_s;
    logic                  wrap_s;
    logic [N_DIGITS-1:0]   an_next_s;
    logic [N_DIGITS-1:0]   blank_mask_s;
    logic [3:0]            nib_sel_s;
    logic [6:0]            dec_s;
    logic [6:0]            seg_next_s;
    logic [6:0]            seg_r;
    logic [N_DIGITS-1:0]   an_r;
    logic                  frame_tick_r;

    assign tick_s = (cnt_r == CNT_LAST);
    assign wrap_s = tick_s && (idx_r == IDX_LAST);

    // Transparent input latch while le is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_r <= {(4*N_DIGITS){1'b0}};
        end else if (!le) begin
            lat_r <= data;
        end
    end

    // Refresh prescaler: one tick every DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Scan index advances on each prescaler tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (wrap_s) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (tick_s) begin
            idx_r <= idx_r + IDX_ONE;
        end
    end

    // One-hot select, nibble mux and leading-zero mask (scan from the most significant digit down)
    always_comb begin
        logic lead_zero_v;
        lead_zero_v  = 1'b1;
        an_next_s    = {N_DIGITS{1'b0}};
        blank_mask_s = {N_DIGITS{1'b0}};
        nib_sel_s    = 4'h0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            an_next_s[i]    = (idx_r == IDX_W'(i));
            nib_sel_s       = nib_sel_s | (lat_r[4*i +: 4] & {4{an_next_s[i]}});
            lead_zero_v     = lead_zero_v & (lat_r[4*i +: 4] == 4'h0);
            blank_mask_s[i] = (i != 0) && lead_zero_v;
        end
    end

    seg7_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .nibble (nib_sel_s),
        .seg    (dec_s)
    );

    // Segment priority: lamp test, blanking, leading-zero blanking, decoded digit
    always_comb begin
        seg_next_s = SEG_OFF;
        if (!lt_n) begin
            seg_next_s = SEG_ALL_ON;
        end else if (!bi_n) begin
            seg_next_s = SEG_OFF;
        end else if (lzb && (|(blank_mask_s & an_next_s))) begin
            seg_next_s = SEG_OFF;
        end else begin
            seg_next_s = dec_s;
        end
    end

    // Output registers; reset leaves every segment and anode inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r        <= SEG_OFF;
            an_r         <= {N_DIGITS{1'b0}};
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= seg_next_s;
            an_r         <= an_next_s;
            frame_tick_r <= wrap_s;
        end
    end

    // Polarity inversion sits after the registers so the pins never glitch
    assign seg        = seg_r ^ {7{(SEG_ACTIVE_LOW != 0)}};
    assign an         = an_r ^ {N_DIGITS{(AN_ACTIVE_LOW != 0)}};
    assign frame_tick = frame_tick_r;

endmodule
